regfile_mp_sb: RTL
==================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the RISC-V core; next generation of the single-write, dual-read register file.
- Adds configurable read and write port counts, write-to-read bypass, and asynchronous clear on reset.
- Adds a per-register pending-write scoreboard, so decode can detect RAW hazards against in-flight writebacks.
- Sits between decode/issue (reads, allocation) and writeback (writes).

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers; must be a power of two, ≥2.
- AW, $clog2(NUM_REGS), register address width.
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 2, number of write ports (1..2).
- ZERO_REG, 1, when 1, register 0 is hardwired to zero and never marked busy.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- raddr  in  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rdata  out  NUM_RD*XLEN  read data, combinational; port i at [i*XLEN +: XLEN].
- rbusy  out  NUM_RD  per read port: addressed register has a pending write.
- we  in  NUM_WR  write enables.
- waddr  in  NUM_WR*AW  write addresses.
- wdata  in  NUM_WR*XLEN  write data.
- alloc_en  in  1  issue marks alloc_addr as pending a future write.
- alloc_addr  in  AW  register to mark busy.
- pend_cnt  out  AW+1  number of registers currently marked busy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers, all scoreboard bits and pend_cnt clear to 0 immediately.
  - rdata and rbusy evaluate to 0 for every address while in reset.
  - Clocked inputs are ignored until rst_n is high.
- Reads (combinational, zero latency):
  - rdata[i] = stored regs[raddr[i]], overridden by bypass.
  - Bypass: if any we[j] is high with waddr[j]==raddr[i] this cycle, rdata[i] = that wdata[j].
  - If several write ports hit the same address, the highest-numbered port wins.
  - ZERO_REG=1 and raddr[i]==0 -> rdata[i]=0, rbusy[i]=0 regardless of writes.
- Writes (rising edge):
  - For each j with we[j] high and waddr[j] not a zeroed x0, regs[waddr[j]] <= wdata[j].
  - Same-address collision: the highest-numbered port's data is stored, consistent with bypass.
- Scoreboard sb[NUM_REGS] (rising edge):
  - Clear: any write to register r clears sb[r].
  - Set: alloc_en high sets sb[alloc_addr]; ignored for x0 when ZERO_REG=1.
  - Same-cycle write and alloc to one register: alloc wins, so sb stays/becomes 1 (new producer issued).
  - Writing a register whose sb=0 is legal; data is stored and sb stays 0.
  - Alloc to an already-busy register is legal; sb stays 1 and pend_cnt is unchanged.
- rbusy[i] = sb[raddr[i]] AND NOT (any we[j] with waddr[j]==raddr[i] this cycle).
  - Rationale: bypassed data is final for the reader.
  - A same-cycle alloc does not affect rbusy until the next cycle.
- pend_cnt:
  - Registered population count of sb, updated incrementally.
  - Next value = current + (bits newly set) − (bits newly cleared).
  - Maximum value is NUM_REGS−ZERO_REG; it never wraps.
- No storage or output is X after reset; all paths are fully defined for any input combination.

Test Plan:
- Reset: write regs[5]=0xDEADBEEF, alloc x7, then pulse rst_n low mid-cycle -> rdata for x5 = 0 immediately; rbusy for x7 = 0; pend_cnt=0.
- Basic write/read: we[0]=1, waddr=3, wdata=0x12345678 at one edge -> next cycle raddr port0=3 gives 0x12345678 and port1=0 gives 0; writing 0xFFFFFFFF to x0 leaves x0 reading 0.
- Bypass and collision: same cycle, we[0]/we[1] both to x9 with 0xAAAA0000/0x5555FFFF and raddr port1=9 -> rdata port1=0x5555FFFF combinationally; next cycle x9 holds 0x5555FFFF.
- Scoreboard: alloc x10 -> next cycle rbusy=1, pend_cnt=1; write x10=0x42 -> rbusy=0 that same cycle and rdata=0x42; next cycle pend_cnt=0.
- Simultaneous alloc+write on x11 (sb already 1) -> sb[11] stays 1, pend_cnt unchanged; alloc x0 -> pend_cnt unchanged.
- Saturation: alloc x1..x31 over 31 cycles -> pend_cnt=31; then two-port writes clearing x1 and x2 in one cycle -> pend_cnt=29.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-to-read bypass and a per-register
// pending-write scoreboard that decode uses to spot RAW hazards on in-flight writebacks.
module regfile_mp_sb #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*XLEN-1:0]   rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*AW-1:0]     waddr,
  input  logic [NUM_WR*XLEN-1:0]   wdata,
  input  logic                     alloc_en,
  input  logic [AW-1:0]            alloc_addr,
  output logic [AW:0]              pend_cnt
);

  localparam int CW = AW + 1;

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [XLEN-1:0]     regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic [CW-1:0]       pend_cnt_q, pend_cnt_d;
  logic [CW-1:0]       set_cnt, clr_cnt;

  logic [AW-1:0]       ra [NUM_RD];
  logic [AW-1:0]       wa [NUM_WR];
  logic [XLEN-1:0]     wd [NUM_WR];
  logic [NUM_WR-1:0]   wr_ok;
  logic                hit;
  logic [XLEN-1:0]     rd_val;

  // Unpack flat buses; wr_ok drops stores aimed at a hardwired x0.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
    wr_ok = '0;
    for (int i = 0; i < NUM_RD; i++) ra[i] = raddr[i*AW +: AW];
    for (int j = 0; j < NUM_WR; j++) begin
      wa[j]    = waddr[j*AW +: AW];
      wd[j]    = wdata[j*XLEN +: XLEN];
      wr_ok[j] = we[j] && !(ZERO_REG != 0 && wa[j] == '0);
    end
  end

  // Later ports overwrite earlier ones, so the highest-numbered port wins a collision.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_ok[j]) regs_d[wa[j]] = wd[j];
    end
  end

  // Writes clear first, then alloc sets, so a new producer overrides a retiring one.
  always_comb begin
    sb_d = sb_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (we[j]) sb_d[wa[j]] = 1'b0;
    end
    if (alloc_en && !(ZERO_REG != 0 && alloc_addr == '0)) sb_d[alloc_addr] = 1'b1;

    set_cnt = '0;
    clr_cnt = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      set_cnt = set_cnt + CW'(sb_d[r] & ~sb_q[r]);
      clr_cnt = clr_cnt + CW'(sb_q[r] & ~sb_d[r]);
    end
    pend_cnt_d = pend_cnt_q + set_cnt - clr_cnt;
  end

  // Read ports: stored value, then any same-cycle write to that address overrides it.
  always_comb begin
    rdata  = '0;
    rbusy  = '0;
    hit    = 1'b0;
    rd_val = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      hit    = 1'b0;
      rd_val = regs_q[ra[i]];
      for (int j = 0; j < NUM_WR; j++) begin
        if (we[j] && wa[j] == ra[i]) begin
          hit    = 1'b1;
          rd_val = wd[j];
        end
      end
      if (rst_n && !(ZERO_REG != 0 && ra[i] == '0)) begin
        rdata[i*XLEN +: XLEN] = rd_val;
        rbusy[i]              = sb_q[ra[i]] & ~hit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register array is reset like any flop because the whole file must read as zero straight after reset; this rules out an SRAM macro.
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      sb_q       <= '0;
      pend_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      sb_q       <= sb_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt = pend_cnt_q;

endmodule
